// File: rtl/itch_frame_pkg.sv
// itch_frame_pkg: shared frame states and length constants for the ITCH frame extractor
package itch_frame_pkg;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, PAYLOAD, DROP, GAP} frame_state_t;
  localparam int ITCH_LEN_W = 16;
  localparam int ITCH_MAX_MSG_LEN = 50;
endpackage

// File: rtl/itch_frame_extractor.sv
// itch_frame_extractor: strips 2-byte big-endian length prefixes and forwards payload bytes to the ITCH parser
//   ports: clk, rst_n (async, active-low); s_valid/s_data/s_ready upstream byte stream;
//   valid_in/byte_in payload strobe, msg_start/msg_end boundary pulses, frame_err oversize pulse, busy.
//   With ITCH_FRAME_STATS_EN defined: msg_count (forwarded messages) and drop_count (oversize frames).
module itch_frame_extractor
  import itch_frame_pkg::*;
#(
  parameter int MAX_MSG_LEN = ITCH_MAX_MSG_LEN,
  parameter int GAP_CYCLES = 1,
  parameter int LEN_W = ITCH_LEN_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       valid_in,
  output logic [7:0] byte_in,
  output logic       msg_start,
  output logic       msg_end,
  output logic       frame_err,
  output logic       busy
`ifdef ITCH_FRAME_STATS_EN
  ,
  output logic [31:0] msg_count,
  output logic [15:0] drop_count
`endif
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_MSG_LEN);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  frame_state_t state, state_n;
  logic [7:0] len_hi, len_hi_n, byte_n;
  logic [LEN_W-1:0] rem, rem_n, len;
  logic [GW-1:0] gap_cnt, gap_n;
  logic first, first_n, valid_n, start_n, end_n, err_n, acc;
  assign s_ready = state != GAP;
  assign busy = state != LEN_HI;
  assign acc = s_valid && s_ready;
  assign len = LEN_W'({len_hi, s_data});
  always_comb begin
    state_n = state;
    len_hi_n = len_hi;
    rem_n = rem;
    gap_n = gap_cnt;
    first_n = first;
    valid_n = 1'b0;
    byte_n = byte_in;
    start_n = 1'b0;
    end_n = 1'b0;
    err_n = 1'b0;
    case (state)
      LEN_HI: if (acc) begin
        len_hi_n = s_data;
        state_n = LEN_LO;
      end
      LEN_LO: if (acc) begin
        rem_n = len;
        first_n = 1'b1;
        err_n = len > MAX_L;
        state_n = (len == '0) ? LEN_HI : (len > MAX_L) ? DROP : PAYLOAD;
      end
      PAYLOAD: if (acc) begin
        valid_n = 1'b1;
        byte_n = s_data;
        start_n = first;
        end_n = rem == ONE;
        first_n = 1'b0;
        rem_n = (rem != '0) ? rem - ONE : rem;
        gap_n = (rem == ONE) ? GW'(GAP_CYCLES) : gap_cnt;
        state_n = (rem > ONE) ? PAYLOAD : (GAP_CYCLES > 0) ? GAP : LEN_HI;
      end
      DROP: if (acc) begin
        rem_n = (rem != '0) ? rem - ONE : rem;
        state_n = (rem > ONE) ? DROP : LEN_HI;
      end
      GAP: begin
        gap_n = (gap_cnt != '0) ? gap_cnt - GW'(1) : gap_cnt;
        state_n = (gap_cnt > GW'(1)) ? GAP : LEN_HI;
      end
      default: state_n = LEN_HI;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LEN_HI;
      len_hi <= '0;
      rem <= '0;
      gap_cnt <= '0;
      first <= 1'b0;
      valid_in <= 1'b0;
      byte_in <= '0;
      msg_start <= 1'b0;
      msg_end <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      len_hi <= len_hi_n;
      rem <= rem_n;
      gap_cnt <= gap_n;
      first <= first_n;
      valid_in <= valid_n;
      byte_in <= byte_n;
      msg_start <= start_n;
      msg_end <= end_n;
      frame_err <= err_n;
    end
  end
`ifdef ITCH_FRAME_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_count <= '0;
      drop_count <= '0;
    end else begin
      msg_count <= msg_count + {31'd0, msg_end};
      drop_count <= drop_count + {15'd0, frame_err};
    end
  end
`endif
endmodule
